// File: rtl/m_div_sequencer.sv
// Iterative PCPI divide sequencer for DIV/DIVU/REM/REMU.
// Uses 32-step restoring division, one quotient bit per cycle, with sign correction on the final step.
module m_div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_busy,
  output logic            pcpi_ready,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd
);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   dvd_reg, dsr_reg, rem_reg, rd_reg;
  logic [4:0]        cnt_reg;
  logic              is_rem_reg, neg_q_reg, neg_r_reg;

  logic              insn_match, signed_op, is_rem, div_zero;
  logic [XLEN-1:0]   abs_rs1, abs_rs2;
  logic              accept, step, last_step;
  logic [XLEN:0]     rem_shift, trial;
  logic              q_bit;
  logic [XLEN-1:0]   rem_step, dvd_step, result;

  // funct3[2] selects the divide half of the M extension
  assign insn_match = (pcpi_insn[6:0] == 7'b0110011) &&
                      (pcpi_insn[31:25] == 7'b0000001) && pcpi_insn[14];
  assign signed_op  = ~pcpi_insn[12];
  assign is_rem     = pcpi_insn[13];
  assign div_zero   = (pcpi_rs2 == '0);
  assign abs_rs1    = (signed_op && pcpi_rs1[XLEN-1]) ? -pcpi_rs1 : pcpi_rs1;
  assign abs_rs2    = (signed_op && pcpi_rs2[XLEN-1]) ? -pcpi_rs2 : pcpi_rs2;

  // Partial remainder is always below the divisor, so a 33-bit trial subtract cannot overflow.
  assign rem_shift  = {rem_reg, dvd_reg[XLEN-1]};
  assign trial      = rem_shift - {1'b0, dsr_reg};
  assign q_bit      = ~trial[XLEN];
  assign rem_step   = q_bit ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign dvd_step   = {dvd_reg[XLEN-2:0], q_bit};
  assign result     = is_rem_reg ? (neg_r_reg ? -rem_step : rem_step)
                                 : (neg_q_reg ? -dvd_step : dvd_step);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pcpi_valid && insn_match) begin
          accept     = 1'b1;
          state_next = div_zero ? DONE : DIVIDE;
        end
      end
      DIVIDE: begin
        if (!pcpi_valid) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_reg == 5'd31) begin
            last_step  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rd_reg     <= '0;
      dvd_reg    <= '0;
      dsr_reg    <= '0;
      rem_reg    <= '0;
      is_rem_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        dvd_reg    <= abs_rs1;
        dsr_reg    <= abs_rs2;
        rem_reg    <= '0;
        cnt_reg    <= '0;
        is_rem_reg <= is_rem;
        neg_q_reg  <= signed_op && (pcpi_rs1[XLEN-1] ^ pcpi_rs2[XLEN-1]);
        neg_r_reg  <= signed_op && pcpi_rs1[XLEN-1];
        // Divide by zero short-circuits: all-ones quotient, remainder is the raw dividend
        if (div_zero)
          rd_reg <= is_rem ? pcpi_rs1 : '1;
      end
      if (step) begin
        rem_reg <= rem_step;
        dvd_reg <= dvd_step;
        cnt_reg <= cnt_reg + 5'd1;
      end
      if (last_step)
        rd_reg <= result;
    end
  end

  assign pcpi_busy  = (state_reg != IDLE);
  assign pcpi_ready = (state_reg == DONE);
  assign pcpi_wr    = (state_reg == DONE);
  assign pcpi_rd    = rd_reg;

endmodule

// File: tb/tb_m_div_sequencer.sv
// Directed testbench for m_div_sequencer.
// Checks results, latency, busy/ready/wr behaviour, abort and reset against hand-computed values.
module tb_m_div_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_busy, pcpi_ready, pcpi_wr;
  logic [31:0] pcpi_rd;

  int n_cmp = 0;
  int n_err = 0;

  m_div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Drives one instruction and reports what the DUT did; callers do the comparisons.
  // lat is the edge index (0 = accept edge) after which ready was seen, -1 on timeout.
  task automatic do_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rd, output logic wr_seen,
                        output logic busy_ok, output logic pulse_ok);
    lat = -1; rd = '0; wr_seen = 1'b0; busy_ok = 1'b1;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'b0000001, f3);
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    for (int e = 0; e < 40 && lat < 0; e++) begin
      @(posedge clk); #1;
      if (!pcpi_busy) busy_ok = 1'b0;
      if (pcpi_ready) begin
        lat = e;
        rd = pcpi_rd;
        wr_seen = pcpi_wr;
      end
    end
    pcpi_valid = 1'b0;
    @(posedge clk); #1;
    pulse_ok = !pcpi_ready && !pcpi_wr && !pcpi_busy;
  endtask

  task automatic test_reset();
    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({pcpi_busy, pcpi_ready, pcpi_wr, pcpi_rd} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b ready=%b wr=%b rd=%h, want all 0",
               pcpi_busy, pcpi_ready, pcpi_wr, pcpi_rd);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // One table walk shared by the arithmetic scenarios: f3, rs1, rs2, expected rd, expected latency
  task automatic run_table(input string name, input logic [2:0] f3s[],
                           input logic [31:0] as[], input logic [31:0] bs[],
                           input logic [31:0] exps[], input int lats[]);
    int lat; logic [31:0] rd; logic wr_seen, busy_ok, pulse_ok;
    for (int i = 0; i < f3s.size(); i++) begin
      do_div(f3s[i], as[i], bs[i], lat, rd, wr_seen, busy_ok, pulse_ok);
      $display("%s[%0d]: f3=%b rs1=%h rs2=%h -> rd=%h lat=%0d", name, i, f3s[i], as[i], bs[i], rd, lat);
      n_cmp++;
      if (lat !== lats[i]) begin
        n_err++; $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, lats[i]);
      end
      n_cmp++;
      if (rd !== exps[i]) begin
        n_err++; $display("FAIL %s[%0d] result: got %h want %h", name, i, rd, exps[i]);
      end
      n_cmp++;
      if (wr_seen !== 1'b1) begin
        n_err++; $display("FAIL %s[%0d] wr_with_ready: got %b want 1", name, i, wr_seen);
      end
      n_cmp++;
      if (busy_ok !== 1'b1) begin
        n_err++; $display("FAIL %s[%0d] busy_held: got %b want 1", name, i, busy_ok);
      end
      n_cmp++;
      if (pulse_ok !== 1'b1) begin
        n_err++; $display("FAIL %s[%0d] ready_one_cycle: got %b want 1", name, i, pulse_ok);
      end
    end
  endtask

  task automatic test_unsigned();
    run_table("unsigned", '{3'b101, 3'b111, 3'b101, 3'b111},
              '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
              '{32'd7, 32'd7, 32'h10, 32'h10},
              '{32'd14, 32'd2, 32'h0FFF_FFFF, 32'hF},
              '{32, 32, 32, 32});
  endtask

  task automatic test_signed();
    run_table("signed", '{3'b100, 3'b110, 3'b110, 3'b100, 3'b100, 3'b110},
              '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FF9C, 32'h8000_0000, 32'h8000_0000},
              '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
              '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF2, 32'h8000_0000, 32'd0},
              '{32, 32, 32, 32, 32, 32});
  endtask

  task automatic test_div_zero();
    run_table("divzero", '{3'b101, 3'b110, 3'b100, 3'b111},
              '{32'h1234_5678, 32'hFFFF_FFFB, 32'd55, 32'hCAFE_0001},
              '{32'd0, 32'd0, 32'd0, 32'd0},
              '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hCAFE_0001},
              '{0, 0, 0, 0});
  endtask

  task automatic test_back_to_back();
    // do_div returns in the first IDLE cycle, so the second accept lands on edge 34
    run_table("b2b", '{3'b101, 3'b111, 3'b100},
              '{32'd1000, 32'd1000, 32'hFFFF_FC18},
              '{32'd3, 32'd3, 32'd10},
              '{32'd333, 32'd1, 32'hFFFF_FF9C},
              '{32, 32, 32});
  endtask

  task automatic test_ignored();
    logic [6:0] f7s[2] = '{7'b0000001, 7'b0000000};
    logic [2:0] f3s[2] = '{3'b000, 3'b101};
    logic seen;
    for (int i = 0; i < 2; i++) begin
      seen = 1'b0;
      @(negedge clk);
      pcpi_valid = 1'b1;
      pcpi_insn  = mk_insn(f7s[i], f3s[i]);
      pcpi_rs1   = 32'd50;
      pcpi_rs2   = 32'd5;
      repeat (40) begin
        @(posedge clk); #1;
        if (pcpi_busy || pcpi_ready || pcpi_wr) seen = 1'b1;
      end
      pcpi_valid = 1'b0;
      $display("ignored[%0d]: insn=%h activity=%b", i, pcpi_insn, seen);
      n_cmp++;
      if (seen !== 1'b0) begin
        n_err++; $display("FAIL ignored[%0d]: got activity=%b want 0", i, seen);
      end
    end
  endtask

  task automatic test_abort();
    logic busy_before, seen;
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'b0000001, 3'b101);
    pcpi_rs1   = 32'd1000;
    pcpi_rs2   = 32'd3;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
    end
    busy_before = pcpi_busy;
    pcpi_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy_before !== 1'b1) begin
      n_err++; $display("FAIL abort_busy_before: got %b want 1", busy_before);
    end
    n_cmp++;
    if (pcpi_busy !== 1'b0) begin
      n_err++; $display("FAIL abort_busy_after: got %b want 0", pcpi_busy);
    end
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (pcpi_ready || pcpi_wr || pcpi_busy) seen = 1'b1;
    end
    $display("abort: busy_before=%b activity_after=%b", busy_before, seen);
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL abort_no_ready: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    pcpi_valid = 1'b1;
    pcpi_insn  = mk_insn(7'b0000001, 3'b101);
    pcpi_rs1   = 32'd1000;
    pcpi_rs2   = 32'd3;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    $display("reset_midop: busy=%b ready=%b wr=%b rd=%h", pcpi_busy, pcpi_ready, pcpi_wr, pcpi_rd);
    n_cmp++;
    if ({pcpi_busy, pcpi_ready, pcpi_wr} !== 3'b000) begin
      n_err++; $display("FAIL reset_midop_flags: got %b%b%b want 000", pcpi_busy, pcpi_ready, pcpi_wr);
    end
    n_cmp++;
    if (pcpi_rd !== 32'd0) begin
      n_err++; $display("FAIL reset_midop_rd: got %h want 00000000", pcpi_rd);
    end
    pcpi_valid = 1'b0;
    resetn = 1'b1;
    run_table("after_reset", '{3'b101}, '{32'd9}, '{32'd3}, '{32'd3}, '{32});
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_ignored();
    test_back_to_back();
    test_abort();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
